// File: rtl/cobra_pkg.sv
// cobra_pkg: shared direction codes, FSM state encoding and helpers for cobra_motion.
package cobra_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DEAD = 2'b10;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t opposite(input dir_t dir);
    return {dir[1], ~dir[0]};
  endfunction

  // Resolve simultaneous presses with priority up > down > left > right.
  function automatic dir_t press_dir(input logic up, input logic down, input logic left);
    if (up)        return DIR_UP;
    else if (down) return DIR_DOWN;
    else if (left) return DIR_LEFT;
    else           return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/cobra_step_timer.sv
// cobra_step_timer: move-interval counter; o_tick_c marks the move cycle, o_step is its registered pulse.
module cobra_step_timer #(
  parameter int unsigned STEP_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_c,
  output logic o_step
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = i_en & ~i_clr & (r_cnt == CNT_LAST);

  // Count while enabled, otherwise hold at zero; wrap on the move cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // One-cycle step pulse aligned with the head update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_step <= 1'b0;
    end else begin
      o_step <= o_tick_c;
    end
  end

endmodule

// File: rtl/cobra_motion.sv
// cobra_motion: snake direction latch, head/body ring, growth and self-collision.
// Define COBRA_WALL_EN to make leaving the grid fatal instead of wrapping.
module cobra_motion
  import cobra_pkg::*;
#(
  parameter int unsigned GRID_W      = 32,
  parameter int unsigned GRID_H      = 24,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned START_LEN   = 3,
  parameter int unsigned STEP_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         start,
  input  logic                         grow,
  input  logic [$clog2(GRID_W)-1:0]    query_x,
  input  logic [$clog2(GRID_H)-1:0]    query_y,
  output logic                         query_hit,
  output logic [1:0]                   cobra_dir,
  output logic [$clog2(GRID_W)-1:0]    head_x,
  output logic [$clog2(GRID_H)-1:0]    head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         step,
  output logic                         dead
);

  localparam int unsigned X_W = $clog2(GRID_W);
  localparam int unsigned Y_W = $clog2(GRID_H);
  localparam int unsigned L_W = $clog2(MAX_LEN + 1);

  localparam logic [X_W-1:0] X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [Y_W-1:0] Y_INIT   = Y_W'(GRID_H / 2);
  localparam logic [L_W-1:0] LEN_MAX  = L_W'(MAX_LEN);
  localparam logic [L_W-1:0] LEN_INIT = L_W'(START_LEN);

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  dir_t           r_dir;
  dir_t           r_pend;
  logic           r_grow_pend;
  logic [L_W-1:0] r_len;
  logic           r_dead;
  logic [X_W-1:0] r_seg_x [MAX_LEN];
  logic [Y_W-1:0] r_seg_y [MAX_LEN];

  logic           w_run;
  logic           w_tick;
  logic           w_press_vld;
  dir_t           w_press_dir;
  logic           w_accept;
  logic [X_W-1:0] w_new_x;
  logic [Y_W-1:0] w_new_y;
  logic           w_wall;
  logic           w_growing;
  logic           w_self_hit;
  logic           w_die;

  // Initial body column for segment i: trails left of the centre, wrapping modulo GRID_W.
  function automatic logic [X_W-1:0] init_x(input int i);
    int v;
    v = (int'(GRID_W / 2) - i) % int'(GRID_W);
    if (v < 0) v = v + int'(GRID_W);
    return X_W'(v);
  endfunction

  assign w_run = (r_state == ST_RUN);

  cobra_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_run),
    .i_clr    (start),
    .o_tick_c (w_tick),
    .o_step   (step)
  );

  // Press decode: priority pick, then drop a reversal of the committed direction.
  always_comb begin
    w_press_vld = up | down | left | right;
    w_press_dir = press_dir(up, down, left);
    w_accept    = w_run & w_press_vld & (w_press_dir != opposite(r_dir));
  end

  // Candidate head for the pending direction, wrapping or flagging a wall hit.
  always_comb begin
    w_new_x = r_seg_x[0];
    w_new_y = r_seg_y[0];
    w_wall  = 1'b0;
    case (r_pend)
      DIR_UP: begin
        if (r_seg_y[0] == '0) begin
          w_new_y = Y_MAX;
`ifdef COBRA_WALL_EN
          w_wall  = 1'b1;
`endif
        end else begin
          w_new_y = r_seg_y[0] - Y_W'(1);
        end
      end
      DIR_DOWN: begin
        if (r_seg_y[0] == Y_MAX) begin
          w_new_y = '0;
`ifdef COBRA_WALL_EN
          w_wall  = 1'b1;
`endif
        end else begin
          w_new_y = r_seg_y[0] + Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (r_seg_x[0] == '0) begin
          w_new_x = X_MAX;
`ifdef COBRA_WALL_EN
          w_wall  = 1'b1;
`endif
        end else begin
          w_new_x = r_seg_x[0] - X_W'(1);
        end
      end
      default: begin
        if (r_seg_x[0] == X_MAX) begin
          w_new_x = '0;
`ifdef COBRA_WALL_EN
          w_wall  = 1'b1;
`endif
        end else begin
          w_new_x = r_seg_x[0] + X_W'(1);
        end
      end
    endcase
  end

  // Self-collision: the tail vacates unless this move grows the snake.
  always_comb begin
    w_growing  = r_grow_pend & (r_len < LEN_MAX);
    w_self_hit = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((L_W'(i + 1) < r_len) || (w_growing && (L_W'(i + 1) == r_len))) begin
        if ((r_seg_x[i] == w_new_x) && (r_seg_y[i] == w_new_y)) begin
          w_self_hit = 1'b1;
        end
      end
    end
    w_die = w_tick & (w_self_hit | w_wall);
  end

  // Renderer occupancy query over live segments only.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((L_W'(i) < r_len) && (r_seg_x[i] == query_x) && (r_seg_y[i] == query_y)) begin
        query_hit = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: start always (re)enters RUN; a fatal move ends in DEAD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_IDLE;
      ST_RUN:  if (w_die) w_state_nxt = ST_DEAD;
      ST_DEAD: w_state_nxt = ST_DEAD;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (start) w_state_nxt = ST_RUN;
  end

  // Datapath: init on reset/start, sample presses and fruit, move on the step cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir       <= DIR_RIGHT;
      r_pend      <= DIR_RIGHT;
      r_grow_pend <= 1'b0;
      r_len       <= LEN_INIT;
      r_dead      <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= Y_INIT;
      end
    end else if (start) begin
      r_dir       <= DIR_RIGHT;
      r_pend      <= DIR_RIGHT;
      r_grow_pend <= 1'b0;
      r_len       <= LEN_INIT;
      r_dead      <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= Y_INIT;
      end
    end else if (w_run) begin
      if (w_accept) r_pend <= w_press_dir;
      if (w_tick) begin
        r_grow_pend <= 1'b0;
      end else if (grow) begin
        r_grow_pend <= 1'b1;
      end
      if (w_tick) begin
        r_dir <= r_pend;
        if (!w_wall) begin
          r_seg_x[0] <= w_new_x;
          r_seg_y[0] <= w_new_y;
          for (int i = 1; i < int'(MAX_LEN); i++) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          if (w_growing) r_len <= r_len + L_W'(1);
        end
        if (w_self_hit || w_wall) r_dead <= 1'b1;
      end
    end
  end

  assign cobra_dir = r_dir;
  assign head_x    = r_seg_x[0];
  assign head_y    = r_seg_y[0];
  assign length    = r_len;
  assign dead      = r_dead;

endmodule

// File: tb/tb_cobra_motion.sv
// tb_cobra_motion: directed stimulus against a queue-based snake model, checked every cycle.
// Follows COBRA_WALL_EN when it is defined for the build.
module tb_cobra_motion;

  localparam int GW = 8;
  localparam int GH = 6;
  localparam int ML = 4;
  localparam int SL = 3;
  localparam int SC = 4;

  logic       clk;
  logic       reset;
  logic       up, down, left, right, start, grow;
  logic [2:0] qx, qy;
  logic       hit;
  logic [1:0] dir;
  logic [2:0] hx, hy;
  logic [2:0] len;
  logic       step, dead;

  int n_checks = 0;
  int n_err    = 0;

  cobra_motion #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .START_LEN(SL), .STEP_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .start(start), .grow(grow), .query_x(qx), .query_y(qy), .query_hit(hit),
    .cobra_dir(dir), .head_x(hx), .head_y(hy), .length(len), .step(step), .dead(dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Snake as a list of cells, head first; its size is the length.
  int   mx[$];
  int   my[$];
  int   m_state;   // 0 idle, 1 run, 2 dead
  int   m_dir, m_pend, m_cnt;
  bit   m_grow, m_step, m_valid;

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit m_occ(input int x, input int y);
    foreach (mx[i]) if (mx[i] == x && my[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_init();
    mx.delete();
    my.delete();
    for (int i = 0; i < SL; i++) begin
      mx.push_back(((GW / 2 - i) % GW + GW) % GW);
      my.push_back(GH / 2);
    end
    m_dir = 3; m_pend = 3; m_cnt = 0; m_grow = 0; m_step = 0; m_valid = 1;
  endtask

  task automatic model_run();
    int  old_pend, p, nx, ny, dx, dy;
    bit  tick, stop, growing, hitself;
    old_pend = m_pend;
    tick     = (m_cnt == SC - 1);
    m_cnt    = tick ? 0 : m_cnt + 1;
    if (up || down || left || right) begin
      p = up ? 0 : down ? 1 : left ? 2 : 3;
      if (p != opp(m_dir)) m_pend = p;
    end
    if (tick) begin
      m_step = 1;
      m_dir  = old_pend;
      dx = (old_pend == 2) ? -1 : (old_pend == 3) ? 1 : 0;
      dy = (old_pend == 0) ? -1 : (old_pend == 1) ? 1 : 0;
      nx = mx[0] + dx;
      ny = my[0] + dy;
      stop = 0;
`ifdef COBRA_WALL_EN
      stop = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`endif
      if (stop) begin
        m_state = 2;
      end else begin
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
        growing = m_grow && (mx.size() < ML);
        if (!growing) begin
          void'(mx.pop_back());
          void'(my.pop_back());
        end
        hitself = m_occ(nx, ny);
        mx.push_front(nx);
        my.push_front(ny);
        if (hitself) m_state = 2;
      end
    end
    if (tick) m_grow = 0;
    else if (grow) m_grow = 1;
  endtask

  initial m_valid = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_init();
      m_state = 0;
    end else begin
      m_step = 0;
      if (start) begin
        m_init();
        m_state = 1;
      end else if (m_state == 1) begin
        model_run();
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_head_x", int'(hx), mx[0]);
      chk("m_head_y", int'(hy), my[0]);
      chk("m_length", int'(len), mx.size());
      chk("m_dir", int'(dir), m_dir);
      chk("m_step", int'(step), int'(m_step));
      chk("m_dead", int'(dead), (m_state == 2) ? 1 : 0);
      chk("m_query_hit", int'(hit), int'(m_occ(int'(qx), int'(qy))));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
    if (qx == 3'd7) begin
      qx = 3'd0;
      qy = (qy == 3'd5) ? 3'd0 : qy + 3'd1;
    end else begin
      qx = qx + 3'd1;
    end
  endtask

  task automatic set_q(input int x, input int y);
    qx = 3'(x);
    qy = 3'(y);
    #1;
  endtask

  task automatic wait_step(output int n);
    bit seen;
    seen = 0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      n++;
      if (step) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("step_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    {up, down, left, right, start, grow} = '0;
    qx = '0;
    qy = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    chk("rst_head_x", int'(hx), 4);
    chk("rst_head_y", int'(hy), 3);
    chk("rst_dir", int'(dir), 3);
    chk("rst_len", int'(len), 3);
    chk("rst_dead", int'(dead), 0);
    chk("rst_step", int'(step), 0);
    repeat (6) cyc();
    chk("idle_no_move", int'(hx), 4);

    // Start, occupancy pins, first move.
    pulse_start();
    set_q(2, 3); chk("q_tail", int'(hit), 1);
    set_q(1, 3); chk("q_beyond_len", int'(hit), 0);
    set_q(4, 2); chk("q_empty", int'(hit), 0);
    wait_step(n);
    chk("first_step_latency", n, 4);
    chk("step1_head_x", int'(hx), 5);
    chk("step1_head_y", int'(hy), 3);

    // Reversal is ignored.
    left = 1'b1; cyc(); left = 1'b0;
    wait_step(n);
    chk("step_period", n + 1, 4);
    chk("rev_dir", int'(dir), 3);
    chk("rev_head_x", int'(hx), 6);

    // Up, then up+down together: priority keeps up.
    up = 1'b1; cyc(); down = 1'b1; cyc(); up = 1'b0; down = 1'b0;
    wait_step(n);
    chk("updown_dir", int'(dir), 0);
    chk("updown_head_y", int'(hy), 2);

    // To the right edge.
    right = 1'b1; cyc(); right = 1'b0;
    wait_step(n);
    chk("edge_head_x", int'(hx), 7);
    wait_step(n);
`ifdef COBRA_WALL_EN
    chk("wall_dead", int'(dead), 1);
    chk("wall_hold_x", int'(hx), 7);
    chk("wall_hold_y", int'(hy), 2);
    cyc();
    chk("wall_no_step", int'(step), 0);
`else
    chk("wrap_x", int'(hx), 0);
    chk("wrap_x_y", int'(hy), 2);
    up = 1'b1; cyc(); up = 1'b0;
    wait_step(n);
    chk("up_y1", int'(hy), 1);
    wait_step(n);
    chk("up_y0", int'(hy), 0);
    wait_step(n);
    chk("wrap_y", int'(hy), 5);
    chk("wrap_y_x", int'(hx), 0);
    set_q(0, 1); chk("q_wrap_body", int'(hit), 1);
    set_q(0, 2); chk("q_vacated", int'(hit), 0);
`endif

    // Growth and saturation.
    pulse_start();
    chk("restart_x", int'(hx), 4);
    cyc();
    grow = 1'b1; cyc(); grow = 1'b0;
    wait_step(n);
    chk("grow_len", int'(len), 4);
    chk("grow_head_x", int'(hx), 5);
    set_q(2, 3); chk("q_grown_tail", int'(hit), 1);
    cyc();
    grow = 1'b1; cyc(); grow = 1'b0;
    wait_step(n);
    chk("grow_sat_len", int'(len), 4);
    chk("grow_sat_x", int'(hx), 6);

    // Collision: up pending, down pressed on the step cycle while still committed right.
    up = 1'b1; cyc(); up = 1'b0;
    cyc(); cyc();
    down = 1'b1; cyc(); down = 1'b0;
    chk("turn_step", int'(step), 1);
    chk("turn_dir", int'(dir), 0);
    chk("turn_head_y", int'(hy), 2);
    wait_step(n);
    chk("coll_dead", int'(dead), 1);
    chk("coll_head_x", int'(hx), 6);
    chk("coll_head_y", int'(hy), 3);
    chk("coll_len", int'(len), 4);
    repeat (6) cyc();
    chk("dead_no_step", int'(step), 0);
    chk("dead_frozen_y", int'(hy), 3);
    set_q(5, 3); chk("q_dead_body", int'(hit), 1);
    set_q(4, 3); chk("q_dead_gone", int'(hit), 0);

    // Recovery and asynchronous reset mid-interval.
    pulse_start();
    chk("recover_dead", int'(dead), 0);
    chk("recover_len", int'(len), 3);
    chk("recover_x", int'(hx), 4);
    up = 1'b1; cyc(); up = 1'b0;
    wait_step(n);
    chk("pre_rst_y", int'(hy), 2);
    cyc();
    reset = 1'b1;
    #1;
    chk("async_head_x", int'(hx), 4);
    chk("async_head_y", int'(hy), 3);
    chk("async_dir", int'(dir), 3);
    chk("async_len", int'(len), 3);
    chk("async_step", int'(step), 0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
